// File: rtl/lut_loader.sv
// Byte-stream loader for the branch-target / data-address lookup table.
// Pairs of bytes (low byte first) form signed DW-bit entries; the table is read combinationally.
module lut_loader #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 10
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [7:0]    InByte,
  input  logic          InValid,
  output logic          InReady,
  input  logic [AW-1:0] Index,
  output logic [DW-1:0] Out,
  output logic          Busy,
  output logic          Done,
  output logic          Err
);

  // state  | meaning
  // S_IDLE | nothing loaded since reset, waiting for Start
  // S_LO   | expecting the low byte of entry ptr
  // S_HI   | expecting the high byte of entry ptr, write on transfer
  // S_DONE | all DEPTH entries written, waiting for a reload Start
  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] ptr;
  logic [7:0]    lo_reg;
  logic          err_q;
  logic [DW-1:0] table_mem [DEPTH];
  logic          xfer;
  logic          ptr_last;
  logic          hi_bad;
  logic [16-DW:0] hi_ext;

  assign xfer     = InValid && InReady;
  assign ptr_last = (ptr == AW'(DEPTH - 1));

  // The high byte must be a sign extension of its low DW-8 bits: all ones or all zeros.
  assign hi_ext = InByte[7:DW-9];
  assign hi_bad = !((&hi_ext) || !(|hi_ext));

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (Start) state_nxt = S_LO;
      S_LO:   if (xfer)  state_nxt = S_HI;
      S_HI:   if (xfer)  state_nxt = ptr_last ? S_DONE : S_LO;
      S_DONE: if (Start) state_nxt = S_LO;
      default:           state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    InReady = 1'b0;
    Busy    = 1'b0;
    Done    = 1'b0;
    case (state)
      S_LO, S_HI: begin
        InReady = 1'b1;
        Busy    = 1'b1;
      end
      S_DONE:  Done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr    <= '0;
      lo_reg <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) table_mem[i] <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            ptr   <= '0;
            err_q <= 1'b0;
          end
        end
        S_LO: begin
          if (xfer) lo_reg <= InByte;
        end
        S_HI: begin
          if (xfer) begin
            table_mem[ptr] <= {InByte[DW-9:0], lo_reg};
            if (hi_bad) err_q <= 1'b1;
            ptr <= ptr_last ? '0 : ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Err = err_q;
  assign Out = table_mem[Index];

endmodule
